// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register for the pipelined MIPS core. It captures the
// decode-stage control bits and decoded operands, and presents them to EX one
// cycle later. It also detects load-use hazards, inserts bubbles on flush or
// load-use, and freezes while the downstream stage is holding.
//
// Optional feature: define HAZARD_STATS_EN to build the two 32-bit hazard
// counters. When it is undefined, stat_bubbles and stat_holds read 0 and no
// counter flops are built.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   id_valid         ID slot holds a real instruction
//   id_<ctrl>        decode control bits (RegDst, MemRead, MemtoReg, MemWrite,
//                    ALUSrc, RegWrite, Branch, Jump) and ALUOp
//   id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_funct
//                    decoded operands and register fields
//   flush            squash the instruction entering EX
//   ex_hold          downstream stall; freeze this register
//   stall_o          combinational; IF/ID and PC must hold this cycle
//   ex_*             registered copies presented to EX (ex_dst is the
//                    selected destination register)
//   stat_bubbles     bubbles inserted (flush or load-use)
//   stat_holds       cycles spent frozen by ex_hold
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_RegDst,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic              ex_RegDst,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [5:0]        ex_funct,
  output logic [31:0]       stat_bubbles,
  output logic [31:0]       stat_holds
);

  logic              uses_rt;
  logic              load_use;
  logic              bubble;
  logic              clear;
  logic              load;
  logic [REG_AW-1:0] dst_p0;

  // Only instructions that actually read rt can be hit through rt; an
  // I-type ALU op writes rt and must not stall on it.
  assign uses_rt  = id_RegDst | id_MemWrite | id_Branch;

  assign load_use = ex_valid & ex_MemRead & (ex_dst != '0) & id_valid &
                    ((ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt)));

  // Reported even when flush wins the edge: the front end resolves its own
  // flush-vs-stall priority.
  assign stall_o  = ~rst & (ex_hold | load_use);

  assign bubble   = flush | load_use;
  assign clear    = rst | (~ex_hold & bubble);
  assign load     = ~ex_hold;
  assign dst_p0   = id_RegDst ? id_rd : id_rt;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (clear) begin
      ex_valid    <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_ALUOp    <= '0;
      ex_pc4      <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      ex_funct    <= '0;
    end else if (load) begin
      // Control is gated by id_valid so an empty slot is always a clean bubble.
      ex_valid    <= id_valid;
      ex_RegDst   <= id_RegDst   & id_valid;
      ex_MemRead  <= id_MemRead  & id_valid;
      ex_MemtoReg <= id_MemtoReg & id_valid;
      ex_MemWrite <= id_MemWrite & id_valid;
      ex_ALUSrc   <= id_ALUSrc   & id_valid;
      ex_RegWrite <= id_RegWrite & id_valid;
      ex_Branch   <= id_Branch   & id_valid;
      ex_Jump     <= id_Jump     & id_valid;
      ex_ALUOp    <= id_ALUOp & {2{id_valid}};
      ex_pc4      <= id_pc4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dst      <= dst_p0;
      ex_funct    <= id_funct;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] bubbles_q;
  logic [31:0] holds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_q <= '0;
      holds_q   <= '0;
    end else begin
      if (ex_hold)
        holds_q <= holds_q + 32'd1;
      else if (bubble)
        bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign stat_bubbles = bubbles_q;
  assign stat_holds   = holds_q;
`else
  assign stat_bubbles = '0;
  assign stat_holds   = '0;
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the pipelined MIPS core; sits directly downstream of the decode-stage control unit.
- Captures its control outputs plus decoded operands each cycle and presents them to the EX stage.
- Integrates load-use hazard detection: holds IF/ID via stall_o and inserts a bubble.
- Also supports flush (taken branch/jump) and a downstream hold (memory wait).

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID slot holds a real instruction
- id_RegDst, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_Branch, id_Jump  in  1 each  decode control bits
- id_ALUOp  in  2  decode ALU op class
- id_pc4  in  DATA_W  PC+4 of ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  register fields
- id_funct  in  6  function field
- flush  in  1  squash the instruction entering EX (taken branch/jump)
- ex_hold  in  1  downstream cannot accept; freeze register
- stall_o  out  1  combinational; IF/ID and PC must hold this cycle
- ex_valid  out  1  EX slot holds a real instruction
- ex_RegDst, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Branch, ex_Jump  out  1 each  registered control
- ex_ALUOp  out  2  registered ALU op class
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_rs, ex_rt  out  REG_AW  registered source fields (forwarding)
- ex_dst  out  REG_AW  registered destination: id_rd if id_RegDst else id_rt
- ex_funct  out  6  registered function field
- stat_bubbles, stat_holds  out  32  hazard counters (see Optional Feature)

Behaviour:
- Reset: all ex_* outputs, ex_valid and counters = 0; stall_o = 0 while rst high.
- Latency: 1 cycle ID->EX for every field.
- uses_rt = id_RegDst | id_MemWrite | id_Branch.
- load_use = ex_valid & ex_MemRead & (ex_dst != 0) & id_valid & ((ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt))).
- stall_o = ex_hold | load_use (combinational, 0 during rst).
- Per-edge priority (highest first):
  1. rst: clear all.
  2. ex_hold: all ex_* and ex_valid keep their values; flush and load_use are ignored this cycle.
  3. flush: bubble; all control outputs 0, ex_valid = 0, data fields don't-care but cleared to 0.
  4. load_use: bubble, same as flush; the ID instruction stays in ID (stall_o=1) and is captured on the next cycle, once the lw has advanced.
  5. Otherwise: capture all id_* fields; ex_valid = id_valid; control bits forced 0 when id_valid = 0.
- Bubble guarantee: ex_valid = 0 implies ex_RegWrite = ex_MemWrite = ex_MemRead = ex_Branch = ex_Jump = 0.
- Load-use lasts exactly one bubble: after the bubble, ex_valid = 0, so load_use deasserts.
- flush together with load_use: flush wins, but stall_o still reflects load_use combinationally. The front end's own flush has priority over its stall.
- Reset mid-hold or mid-stall: state cleared; the next cycle resumes normal capture.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stat_bubbles increments on every edge where a load_use or flush bubble is inserted (not during hold).
  - stat_holds increments on every edge with ex_hold = 1.
  - Both wrap at 2^32; both are cleared by rst.
- Undefined: both ports tied to constant 0 and no counter flops are built.

Test Plan:
- Reset: rst=1 with random id_* -> all ex_* = 0, ex_valid = 0, stall_o = 0; rst drop -> first valid R-type (rd=3, rt=2) appears with ex_dst = 3, ex_RegWrite = 1 after 1 cycle.
- Load-use: lw $5 (ex_dst=5, ex_MemRead=1) followed by add rs=5 in ID -> stall_o = 1 for one cycle, next ex_valid = 0 with all control 0, then the add is captured; stat_bubbles = 1.
- No false hazard: lw $5 followed by addi rt=5, rs=4 (uses_rt = 0) -> stall_o = 0, no bubble; lw to $0 followed by use of $0 -> no stall.
- Flush: beq taken, flush = 1 with valid sw in ID -> next cycle ex_valid = 0, ex_MemWrite = 0.
- Hold: ex_hold = 1 for 3 cycles with changing id_* -> ex_* unchanged, stall_o = 1 throughout, stat_holds = 3; flush asserted during hold is ignored.
- Priority corner: ex_hold and load_use and flush all asserted -> register frozen; after hold drops with load_use still true -> one bubble inserted.
